sr_cmd_sequencer: RTL and testbench
===================================

// Module: sr_cmd_sequencer
// PURPOSE
//  Upstream command stage for the SR flip-flop (T-flop based) in this directory.
//  It synchronises and debounces raw set/clear request lines and emits clean
//  one-cycle s/r pulses, never s=r=1. It checks the flop's q feedback for the
//  expected result and flags conflicts and missing acknowledgements.
// PARAMETERS
//  DEBOUNCE_CYCLES  4  consecutive stable synchronised samples before a level is accepted (>=1)
//  HOLDOFF_CYCLES   2  idle cycles enforced after each command completes (>=0)
//  ACK_TIMEOUT      3  cycles allowed for q_fb to reach the expected value (>=1)
// PORTS
//  clk       in   1  clock, all state on posedge
//  rst       in   1  asynchronous, ACTIVE-LOW reset (rst=0 resets)
//  set_req   in   1  raw asynchronous set request, level
//  clr_req   in   1  raw asynchronous clear request, level
//  q_fb      in   1  q output of downstream SR flop
//  s         out  1  set pulse to SR flop, registered
//  r         out  1  reset pulse to SR flop, registered
//  busy      out  1  high in any state other than IDLE
//  conflict  out  1  one-cycle pulse: set and clear edges accepted in the same cycle
//  ack_err   out  1  one-cycle pulse: q_fb did not match within ACK_TIMEOUT
// BEHAVIOUR
//  Reset (rst=0, async): s=r=busy=conflict=ack_err=0; FSM=IDLE; sync, debounce,
//   pending, and counters cleared; debounced levels=0.
//  Input path per line: 2-flop synchroniser -> debounce counter. Accepted level
//   changes only after DEBOUNCE_CYCLES equal samples; any differing sample restarts
//   the count. Command source = rising edge of the accepted level only.
//  Latency: req high and stable from cycle 0 -> s (or r) high in cycle 2+DEBOUNCE_CYCLES+1
//   (7 with defaults), when FSM is IDLE.
//  FSM: IDLE -> ISSUE -> WAIT_ACK -> HOLDOFF -> IDLE.
//   IDLE: on accepted edge (or valid pending slot) -> ISSUE; pending is consumed first.
//   ISSUE: exactly one cycle; s=1 for SET, r=1 for CLR; -> WAIT_ACK.
//   WAIT_ACK: expect q_fb=1 (SET) / 0 (CLR); match -> HOLDOFF; no match after
//    ACK_TIMEOUT cycles -> ack_err pulse, -> HOLDOFF.
//   HOLDOFF: HOLDOFF_CYCLES cycles (0 = single transit cycle) -> IDLE.
//  Both edges accepted in the same cycle: no command issued, conflict pulses,
//   pending slot unchanged.
//  Edges arriving while busy: one-deep pending slot; later edge overwrites
//   (a CLR after a pending SET leaves CLR pending). Same type merges.
//  Edge coincident with the busy->IDLE cycle is taken directly, not dropped.
//  s and r are mutually exclusive in every cycle by construction; high only in ISSUE.
//  Commands are issued even if q_fb already matches; the SR flop holds, and ack passes.
//  rst asserted mid-command: outputs drop immediately; no command is resumed.
//  Counters saturate, never wrap; width = $clog2(max value + 1).
// STRUCTURE
//  Shared header sr_defs.vh: FSM state localparams (IDLE/ISSUE/WAIT_ACK/HOLDOFF),
//   command codes (CMD_NONE/CMD_SET/CMD_CLR).
//  Sub-module sr_debounce (synchroniser + debounce counter + rising-edge pulse),
//   instantiated twice, parameter DEBOUNCE_CYCLES.
//  Top holds FSM, pending slot, ack/holdoff counters, and output registers.
// TESTING (defaults; bench instantiates this block driving sr_using_t, q_fb=q)
//  1 Reset: drive rst=0 mid-cycle with reqs high -> all outputs 0 immediately;
//    release -> no s/r until a fresh debounced edge.
//  2 set_req 0->1 held 10 cycles -> s=1 for exactly one cycle, 7 cycles after
//    first sample; q_fb=1 next cycle; ack_err stays 0; busy for 1+1+2 cycles.
//  3 Glitch: set_req high 3 cycles then low -> no s pulse.
//    Glitch of 4+ stable samples -> one pulse.
//  4 set_req and clr_req rise in the same clock, equal paths -> conflict=1 one cycle,
//    s=r=0 throughout.
//  5 While busy after SET, raise clr_req then set_req again -> after HOLDOFF,
//    single s pulse (overwrite); no r pulse.
//  6 Force q_fb stuck at 0, issue SET -> ack_err pulses in 3rd WAIT_ACK cycle;
//    FSM returns to IDLE after HOLDOFF.

Source files
------------

// File: rtl/sr_cmd_sequencer_pkg.sv
// rtl/sr_cmd_sequencer_pkg.sv - shared FSM states, command codes and edge decode for the SR command sequencer
package sr_cmd_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_HOLDOFF  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_SET  = 2'd1,
    CMD_CLR  = 2'd2
  } cmd_e;

  // Simultaneous set and clear edges cancel each other out.
  function automatic cmd_e edge_cmd(input logic set_rise, input logic clr_rise);
    if (set_rise && !clr_rise) return CMD_SET;
    if (clr_rise && !set_rise) return CMD_CLR;
    return CMD_NONE;
  endfunction

endpackage

// File: rtl/sr_cmd_sequencer_debounce.sv
// rtl/sr_cmd_sequencer_debounce.sv - 2-flop synchroniser, debounce counter and rising-edge pulse for one request line
module sr_cmd_sequencer_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_i,
  output logic rise_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          level_q;
  logic          rise_q;
  logic [CW-1:0] cnt_q;

  // cnt_q counts consecutive samples that differ from the accepted level;
  // a sample equal to the level restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b00;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q <= {sync_q[0], din_i};
      rise_q <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= sync_q[1];
        rise_q  <= sync_q[1];
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/sr_cmd_sequencer.sv
// rtl/sr_cmd_sequencer.sv - debounced set/clear command sequencer with q feedback check for a downstream SR flop
module sr_cmd_sequencer
  import sr_cmd_sequencer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned HOLDOFF_CYCLES  = 2,
  parameter int unsigned ACK_TIMEOUT     = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic clr_req,
  input  logic q_fb,
  output logic s,
  output logic r,
  output logic busy,
  output logic conflict,
  output logic ack_err
);

  // A zero holdoff still costs one transit cycle through HOLDOFF.
  localparam int unsigned HOLD_N = (HOLDOFF_CYCLES < 1) ? 1 : HOLDOFF_CYCLES;
  localparam int unsigned ACK_W  = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_N + 1);
  localparam logic [ACK_W-1:0]  ACK_LAST  = ACK_W'(ACK_TIMEOUT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_N - 1);

  logic set_rise;
  logic clr_rise;
  cmd_e new_cmd_d;
  cmd_e issue_cmd_d;
  logic ack_match_d;

  state_e             state_q;
  cmd_e               cmd_q;
  cmd_e               pend_q;
  logic [ACK_W-1:0]   ack_cnt_q;
  logic [HOLD_W-1:0]  hold_cnt_q;
  logic               s_q;
  logic               r_q;
  logic               conflict_q;
  logic               ack_err_q;

  sr_cmd_sequencer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_db (
    .clk    (clk),
    .rst_n  (rst),
    .din_i  (set_req),
    .rise_o (set_rise)
  );

  sr_cmd_sequencer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_db (
    .clk    (clk),
    .rst_n  (rst),
    .din_i  (clr_req),
    .rise_o (clr_rise)
  );

  assign new_cmd_d   = edge_cmd(set_rise, clr_rise);
  assign issue_cmd_d = (pend_q != CMD_NONE) ? pend_q : new_cmd_d;
  assign ack_match_d = (cmd_q == CMD_SET) ? q_fb : ~q_fb;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cmd_q      <= CMD_NONE;
      pend_q     <= CMD_NONE;
      ack_cnt_q  <= '0;
      hold_cnt_q <= '0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      conflict_q <= 1'b0;
      ack_err_q  <= 1'b0;
    end else begin
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      ack_err_q  <= 1'b0;
      conflict_q <= set_rise & clr_rise;
      // While busy the newest edge owns the one-deep slot; a conflict leaves it alone.
      if (state_q != ST_IDLE && new_cmd_d != CMD_NONE) pend_q <= new_cmd_d;
      case (state_q)
        ST_IDLE: begin
          if (issue_cmd_d != CMD_NONE) begin
            state_q <= ST_ISSUE;
            cmd_q   <= issue_cmd_d;
            s_q     <= (issue_cmd_d == CMD_SET);
            r_q     <= (issue_cmd_d == CMD_CLR);
            pend_q  <= (pend_q != CMD_NONE) ? new_cmd_d : CMD_NONE;
          end
        end
        ST_ISSUE: begin
          state_q   <= ST_WAIT_ACK;
          ack_cnt_q <= '0;
        end
        ST_WAIT_ACK: begin
          if (ack_match_d) begin
            state_q    <= ST_HOLDOFF;
            hold_cnt_q <= '0;
          end else if (ack_cnt_q == ACK_LAST) begin
            ack_err_q  <= 1'b1;
            state_q    <= ST_HOLDOFF;
            hold_cnt_q <= '0;
          end else begin
            ack_cnt_q <= ack_cnt_q + ACK_W'(1);
          end
        end
        ST_HOLDOFF: begin
          if (hold_cnt_q == HOLD_LAST) state_q <= ST_IDLE;
          else hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s        = s_q;
  assign r        = r_q;
  assign busy     = (state_q != ST_IDLE);
  assign conflict = conflict_q;
  assign ack_err  = ack_err_q;

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// tb/tb_sr_cmd_sequencer.sv - directed self-checking bench for sr_cmd_sequencer driving an SR flop model
module tb_sr_cmd_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic set_req;
  logic clr_req;
  logic force0;

  logic s0, r0, busy0, conflict0, ack_err0, q0, q_fb0;
  logic sh, rh, busyh, conflicth, ack_errh, q1;

  int n_cmp = 0;
  int n_bad = 0;

  int cyc, s_cnt, r_cnt, busy_cnt, conf_cnt, ack_cnt, ack_in_busy, s_at;
  int sh_cnt, rh_cnt;
  int both_cnt = 0;
  logic q_at8;

  always #5 clk = ~clk;

  assign q_fb0 = force0 ? 1'b0 : q0;

  sr_cmd_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .set_req  (set_req),
    .clr_req  (clr_req),
    .q_fb     (q_fb0),
    .s        (s0),
    .r        (r0),
    .busy     (busy0),
    .conflict (conflict0),
    .ack_err  (ack_err0)
  );

  sr_cmd_sequencer #(.HOLDOFF_CYCLES(16)) dut_h (
    .clk      (clk),
    .rst      (rst),
    .set_req  (set_req),
    .clr_req  (clr_req),
    .q_fb     (q1),
    .s        (sh),
    .r        (rh),
    .busy     (busyh),
    .conflict (conflicth),
    .ack_err  (ack_errh)
  );

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q0 <= 1'b0;
      q1 <= 1'b0;
    end else begin
      if (s0) q0 <= 1'b1; else if (r0) q0 <= 1'b0;
      if (sh) q1 <= 1'b1; else if (rh) q1 <= 1'b0;
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    cyc = 0; s_cnt = 0; r_cnt = 0; busy_cnt = 0; conf_cnt = 0;
    ack_cnt = 0; ack_in_busy = 0; s_at = 0; sh_cnt = 0; rh_cnt = 0; q_at8 = 1'bx;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (s0) begin
      s_cnt++;
      if (s_at == 0) s_at = cyc;
    end
    if (r0) r_cnt++;
    if (s0 && r0) both_cnt++;
    if (busy0) busy_cnt++;
    if (conflict0) conf_cnt++;
    if (ack_err0) begin
      ack_cnt++;
      if (busy0) ack_in_busy++;
    end
    if (sh) sh_cnt++;
    if (rh) rh_cnt++;
    if (cyc == 8) q_at8 = q_fb0;
  endtask

  initial begin
    rst = 1'b0; set_req = 1'b0; clr_req = 1'b0; force0 = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", int'({s0, r0, busy0, conflict0, ack_err0}), 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Basic SET: latency, single pulse, ack, busy length.
    clear_stats();
    set_req = 1'b1;
    repeat (10) tick();
    set_req = 1'b0;
    repeat (30) tick();
    check_eq("set_latency", s_at, 7);
    check_eq("set_pulses", s_cnt, 1);
    check_eq("set_no_r", r_cnt, 0);
    check_eq("set_q_next", int'(q_at8), 1);
    check_eq("set_no_ack_err", ack_cnt, 0);
    check_eq("set_busy_len", busy_cnt, 4);

    // Three-sample glitch is rejected.
    clear_stats();
    set_req = 1'b1;
    repeat (3) tick();
    set_req = 1'b0;
    repeat (15) tick();
    check_eq("glitch3_no_s", s_cnt, 0);

    // Four stable samples are accepted; q already high, command still issued.
    clear_stats();
    set_req = 1'b1;
    repeat (4) tick();
    set_req = 1'b0;
    repeat (30) tick();
    check_eq("glitch4_one_s", s_cnt, 1);
    check_eq("glitch4_no_ack_err", ack_cnt, 0);
    check_eq("glitch4_busy_len", busy_cnt, 4);

    // Simultaneous edges: conflict only.
    clear_stats();
    set_req = 1'b1; clr_req = 1'b1;
    repeat (10) tick();
    set_req = 1'b0; clr_req = 1'b0;
    repeat (30) tick();
    check_eq("conflict_pulses", conf_cnt, 1);
    check_eq("conflict_no_s", s_cnt, 0);
    check_eq("conflict_no_r", r_cnt, 0);
    check_eq("conflict_not_busy", busy_cnt, 0);

    // Plain CLR.
    clear_stats();
    clr_req = 1'b1;
    repeat (8) tick();
    clr_req = 1'b0;
    repeat (30) tick();
    check_eq("clr_pulses", r_cnt, 1);
    check_eq("clr_no_s", s_cnt, 0);
    check_eq("clr_q_low", int'(q_fb0), 0);

    // SET, then CLR edge and SET edge while dut_h is busy: pending overwritten to SET.
    // On dut the late SET edge lands in the last HOLDOFF cycle of the CLR and must not be lost.
    clear_stats();
    set_req = 1'b1;
    repeat (4) tick();
    set_req = 1'b0;
    repeat (4) tick();
    clr_req = 1'b1;
    repeat (4) tick();
    set_req = 1'b1;
    repeat (8) tick();
    set_req = 1'b0; clr_req = 1'b0;
    repeat (60) tick();
    check_eq("ovw_h_s_pulses", sh_cnt, 2);
    check_eq("ovw_h_no_r", rh_cnt, 0);
    check_eq("edge_at_idle_s", s_cnt, 2);
    check_eq("edge_at_idle_r", r_cnt, 1);

    // q_fb stuck low: SET times out with one ack_err pulse, then returns to IDLE.
    force0 = 1'b1;
    clear_stats();
    set_req = 1'b1;
    repeat (10) tick();
    set_req = 1'b0;
    repeat (30) tick();
    force0 = 1'b0;
    check_eq("timeout_s", s_cnt, 1);
    check_eq("timeout_ack_err", ack_cnt, 1);
    check_eq("timeout_ack_in_busy", ack_in_busy, 1);
    check_eq("timeout_busy_len", busy_cnt, 6);
    check_eq("timeout_back_idle", int'(busy0), 0);

    // Async reset mid-command with both requests high.
    clear_stats();
    set_req = 1'b1;
    repeat (7) tick();
    check_eq("pre_reset_s", int'(s0), 1);
    clr_req = 1'b1;
    #2 rst = 1'b0;
    #1 check_eq("async_reset_out", int'({s0, r0, busy0, conflict0, ack_err0}), 0);
    check_eq("async_reset_out_h", int'({sh, rh, busyh, conflicth, ack_errh}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    clear_stats();
    repeat (20) tick();
    check_eq("post_reset_no_s", s_cnt, 0);
    check_eq("post_reset_no_r", r_cnt, 0);
    check_eq("post_reset_conflict", conf_cnt, 1);
    set_req = 1'b0; clr_req = 1'b0;
    repeat (20) tick();

    check_eq("s_r_mutex", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
